// File: rtl/aha_clk_div_sequencer_if.sv
// Ratio-change request/acknowledge handshake between a requester
// (software or power-management FSM) and aha_clk_div_sequencer.
interface aha_clk_div_sequencer_if;
  logic       sel_req;
  logic [2:0] sel_val;
  logic       sel_ack;
  logic       sel_err;
  logic       busy;

  modport master (
    output sel_req,
    output sel_val,
    input  sel_ack,
    input  sel_err,
    input  busy
  );

  modport slave (
    input  sel_req,
    input  sel_val,
    output sel_ack,
    output sel_err,
    output busy
  );
endinterface

// File: rtl/aha_clk_div_sequencer.sv
// Power-of-two clock divider (N = 2^sel) with a glitch-free ratio-change
// sequencer: drain to a low phase, force a low gap, then load the new ratio.
module aha_clk_div_sequencer #(
  parameter int MAX_SEL    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int RESET_SEL  = 1
) (
  input  logic                    i_clk_in,
  input  logic                    i_reset,
  aha_clk_div_sequencer_if.slave  s_if,
  output logic [2:0]              o_cur_sel,
  output logic                    o_q,
  output logic                    o_clk_en
);

  localparam int CNT_W = MAX_SEL - 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       SEL_RST  = 3'(RESET_SEL);
  localparam logic [2:0]       SEL_MAX  = 3'(MAX_SEL);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_GAP,
    S_LOAD
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_cur_sel;
  logic [2:0]       r_pend;
  logic             r_q;
  logic             r_clk_en;
  logic             r_ack;
  logic             r_err;
  logic             r_busy;

  logic [CNT_W-1:0] w_half_m1;
  logic             w_tog;
  logic             w_bad;
  logic             w_take;

  assign w_half_m1 = CNT_W'((32'd1 << (r_cur_sel - 3'd1)) - 32'd1);
  assign w_tog     = (r_cnt == w_half_m1);
  assign w_bad     = (s_if.sel_val == 3'd0) || (s_if.sel_val > SEL_MAX);
  assign w_take    = s_if.sel_req && !r_busy;

  always_ff @(posedge i_clk_in or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_cur_sel <= SEL_RST;
      r_pend    <= SEL_RST;
      r_q       <= 1'b0;
      r_clk_en  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_RUN: begin
          r_busy <= 1'b0;
          if (w_tog) begin
            r_cnt    <= '0;
            r_q      <= ~r_q;
            r_clk_en <= ~r_q;
          end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_clk_en <= 1'b0;
          end
          if (w_take) begin
            r_pend <= s_if.sel_val;
            r_busy <= 1'b1;
            if (w_bad) begin
              r_err <= 1'b1;
            end else if (s_if.sel_val == r_cur_sel) begin
              r_ack <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              // Already low: suppress the pending rise so no runt escapes.
              if (!r_q) begin
                r_q      <= 1'b0;
                r_clk_en <= 1'b0;
                r_cnt    <= r_cnt;
              end
            end
          end
        end
        S_DRAIN: begin
          r_clk_en <= 1'b0;
          if (!r_q) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else if (w_tog) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          r_q      <= 1'b0;
          r_clk_en <= 1'b0;
          if (r_cnt == GAP_LAST) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_cur_sel <= r_pend;
            r_ack     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOAD: begin
          r_state  <= S_RUN;
          r_cnt    <= '0;
          r_q      <= 1'b0;
          r_clk_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.sel_ack = r_ack;
  assign s_if.sel_err = r_err;
  assign s_if.busy    = r_busy;
  assign o_cur_sel    = r_cur_sel;
  assign o_q          = r_q;
  assign o_clk_en     = r_clk_en;

endmodule

// File: tb/tb_aha_clk_div_sequencer.sv
// Directed bench for aha_clk_div_sequencer: a per-cycle vector table
// followed by hand-written multi-cycle ratio-change and reset sequences.
module tb_aha_clk_div_sequencer;

  typedef struct {
    logic       req;
    logic [2:0] val;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] cur_sel;
  logic       q;
  logic       clk_en;
  int         n_vec;
  int         n_bad;
  vec_t       tbl[28];

  aha_clk_div_sequencer_if sif();

  aha_clk_div_sequencer #(
    .MAX_SEL(4),
    .GAP_CYCLES(2),
    .RESET_SEL(1)
  ) dut (
    .i_clk_in (clk),
    .i_reset  (rst),
    .s_if     (sif),
    .o_cur_sel(cur_sel),
    .o_q      (q),
    .o_clk_en (clk_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [2:0] s,
                              input logic eq, input logic ec,
                              input logic ea, input logic ee,
                              input logic eb, input logic [2:0] es);
    vec_t v;
    v.req = r;
    v.val = s;
    v.exp = {eq, ec, ea, ee, eb, es};
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {q, clk_en, sif.sel_ack, sif.sel_err, sif.busy, cur_sel};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] s);
    sif.sel_req = r;
    sif.sel_val = s;
    @(posedge clk);
    #1;
  endtask

  task automatic expo(input string nm, input logic eq, input logic ec,
                      input logic ea, input logic eb, input logic [2:0] es);
    chk(nm, 32'(outs()), 32'({eq, ec, ea, 1'b0, eb, es}));
  endtask

  // Hold a request until ACK/ERR; report latency and Q-high cycles seen.
  task automatic req_until_ack(input logic [2:0] s, output int lat,
                               output int hi);
    lat = 0;
    hi  = 0;
    do begin
      step(1'b1, s);
      lat++;
      if (q && !sif.sel_ack) hi++;
    end while (!sif.sel_ack && !sif.sel_err && lat < 40);
  endtask

  initial begin
    int lat;
    int hi;
    int n;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    sif.sel_req = 1'b0;
    sif.sel_val = 3'd0;

    tbl[0]  = mk(0, 0, 1, 1, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 1, 1, 0, 0, 0, 1);
    tbl[3]  = mk(1, 3, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(1, 3, 0, 0, 0, 0, 1, 1);
    tbl[5]  = mk(1, 3, 0, 0, 0, 0, 1, 1);
    tbl[6]  = mk(1, 3, 0, 0, 1, 0, 1, 3);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[11] = mk(0, 0, 1, 1, 0, 0, 0, 3);
    tbl[12] = mk(0, 0, 1, 0, 0, 0, 0, 3);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 0, 3);
    tbl[14] = mk(0, 0, 1, 0, 0, 0, 0, 3);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[19] = mk(0, 0, 1, 1, 0, 0, 0, 3);
    tbl[20] = mk(1, 0, 1, 0, 0, 1, 1, 3);
    tbl[21] = mk(0, 0, 1, 0, 0, 0, 0, 3);
    tbl[22] = mk(1, 5, 1, 0, 0, 1, 1, 3);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 3);
    tbl[24] = mk(1, 3, 0, 0, 1, 0, 1, 3);
    tbl[25] = mk(1, 3, 0, 0, 0, 0, 0, 3);
    tbl[26] = mk(1, 3, 0, 0, 1, 0, 1, 3);
    tbl[27] = mk(0, 0, 1, 1, 0, 0, 0, 3);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(outs()), 32'({5'b00000, 3'd1}));
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].req, tbl[i].val);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // sel 3 -> 4 captured in the first high cycle: 3 more high, 2 gap, load
    req_until_ack(3'd4, lat, hi);
    chk("lat_3to4", 32'(lat), 32'd7);
    chk("hi_3to4", 32'(hi), 32'd3);
    chk("cur_4", 32'(cur_sel), 32'd4);

    n = 0;
    step(1'b0, 3'd0);
    while (!q && n < 40) begin
      n++;
      step(1'b0, 3'd0);
    end
    chk("low_after_load4", 32'(n), 32'd8);
    chk("ce_first_rise4", 32'(clk_en), 32'd1);

    // sel 4 -> 1 captured at start of high half
    req_until_ack(3'd1, lat, hi);
    chk("lat_4to1", 32'(lat), 32'd11);
    chk("hi_4to1", 32'(hi), 32'd7);
    chk("cur_1", 32'(cur_sel), 32'd1);

    step(0, 0); expo("div2_a", 0, 0, 0, 0, 1);
    step(0, 0); expo("div2_b", 1, 1, 0, 0, 1);
    step(0, 0); expo("div2_c", 0, 0, 0, 0, 1);
    step(0, 0); expo("div2_d", 1, 1, 0, 0, 1);
    step(0, 0); expo("div2_e", 0, 0, 0, 0, 1);

    // capture while Q low: rise suppressed, latency 1+2+1
    step(1, 2); expo("q0cap_drain", 0, 0, 0, 1, 1);
    step(1, 2); expo("q0cap_gap1", 0, 0, 0, 1, 1);
    step(1, 2); expo("q0cap_gap2", 0, 0, 0, 1, 1);
    step(1, 2); expo("q0cap_load", 0, 0, 1, 1, 2);
    step(0, 0); expo("sel2_r1", 0, 0, 0, 0, 2);
    step(0, 0); expo("sel2_r2", 0, 0, 0, 0, 2);
    step(0, 0); expo("sel2_r3", 1, 1, 0, 0, 2);

    // same-value request at sel 2
    step(1, 2); expo("same2_ack", 1, 0, 1, 1, 2);
    step(0, 0); expo("same2_after", 0, 0, 0, 0, 2);

    // reset while in GAP
    step(1, 3); expo("rg_drain", 0, 0, 0, 1, 2);
    step(1, 3); expo("rg_gap", 0, 0, 0, 1, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_gap", 32'(outs()), 32'({5'b00000, 3'd1}));
    sif.sel_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_held", 32'(outs()), 32'({5'b00000, 3'd1}));
    rst = 1'b0;
    step(0, 0); expo("post_rst_a", 1, 1, 0, 0, 1);
    step(0, 0); expo("post_rst_b", 0, 0, 0, 0, 1);
    step(0, 0); expo("post_rst_c", 1, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
